// File: rtl/spi_exp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : spi_exp_pkg
// Summary  : Shared constants, command-byte fields and FSM encoding for the
//            SPI IO-expander frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package spi_exp_pkg;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;

  localparam int CMD_RD_BIT  = 7;
  localparam int CMD_RSVD_HI = 6;
  localparam int CMD_RSVD_LO = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_WR      = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_RD_HOLD = 3'd5;
  localparam state_t ST_ERR     = 3'd6;

  function automatic logic cmd_rsvd_set(input logic [DATA_W-1:0] cmd);
    return |cmd[CMD_RSVD_HI:CMD_RSVD_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_addr_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_addr_counter
// Summary  : Loadable register-address counter; increments wrap modulo 2^ADDR_W.
// Revision : 1.0 - initial release
// ============================================================================
module spi_addr_counter #(
  parameter int ADDR_W = spi_exp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_frame_controller
// Summary  : Decodes the SPI command byte and streams data bytes into or out
//            of the register file with an auto-incrementing address.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_controller #(
  parameter int ADDR_W = spi_exp_pkg::ADDR_W,
  parameter int DATA_W = spi_exp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              busy,
  output logic              err
);

  import spi_exp_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_cs_prev;
  logic              w_cs_rise;

  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_re;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_load;
  logic              r_err;

  logic              w_we_nxt;
  logic              w_re_nxt;
  logic              w_load_nxt;
  logic              w_err_nxt;
  logic              w_addr_load;
  logic              w_addr_inc;
  logic [ADDR_W-1:0] w_addr;

  assign w_cs_rise = cs_active & ~r_cs_prev;

  spi_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_addr_load),
    .load_val (rx_data[ADDR_W-1:0]),
    .inc      (w_addr_inc),
    .count    (w_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cs_prev <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cs_prev <= cs_active;
    end
  end

  // A low chip-select overrides every state and any byte arriving with it.
  always_comb begin
    w_next_state = r_state;
    if (!cs_active) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_cs_rise) w_next_state = ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            if (cmd_rsvd_set(rx_data))   w_next_state = ST_ERR;
            else if (rx_data[CMD_RD_BIT]) w_next_state = ST_RD_REQ;
            else                          w_next_state = ST_WR;
          end
        end
        ST_WR:      w_next_state = ST_WR;
        ST_RD_REQ:  w_next_state = ST_RD_WAIT;
        ST_RD_WAIT: w_next_state = ST_RD_HOLD;
        ST_RD_HOLD: if (rx_valid) w_next_state = ST_RD_REQ;
        ST_ERR:     w_next_state = ST_ERR;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // reg_re is raised on entry to RD_REQ, so reg_rdata is ready in RD_WAIT and
  // is captured into tx_data on the RD_WAIT edge. The write address advances
  // on the cycle the write strobe is presented.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_load_nxt  = 1'b0;
    w_addr_load = 1'b0;
    w_addr_inc  = r_we;
    w_err_nxt   = r_err;
    if (cs_active) begin
      case (r_state)
        ST_IDLE: if (w_cs_rise) w_err_nxt = 1'b0;
        ST_CMD: begin
          if (rx_valid) begin
            if (cmd_rsvd_set(rx_data)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_addr_load = 1'b1;
              w_re_nxt    = rx_data[CMD_RD_BIT];
            end
          end
        end
        ST_WR:      w_we_nxt = rx_valid;
        ST_RD_REQ:  if (rx_valid) w_err_nxt = 1'b1;
        ST_RD_WAIT: begin
          w_load_nxt = 1'b1;
          w_addr_inc = 1'b1;
          if (rx_valid) w_err_nxt = 1'b1;
        end
        ST_RD_HOLD: w_re_nxt = rx_valid;
        default:    w_err_nxt = r_err;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_re      <= 1'b0;
      r_tx_data <= '0;
      r_tx_load <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we      <= w_we_nxt;
      r_re      <= w_re_nxt;
      r_tx_load <= w_load_nxt;
      r_err     <= w_err_nxt;
      if (w_we_nxt)   r_wdata   <= rx_data;
      if (w_load_nxt) r_tx_data <= reg_rdata;
    end
  end

  assign reg_addr  = w_addr;
  assign reg_we    = r_we;
  assign reg_wdata = r_wdata;
  assign reg_re    = r_re;
  assign tx_data   = r_tx_data;
  assign tx_load   = r_tx_load;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_controller
// Summary  : Bench for spi_frame_controller with a register-file model and a
//            frame-level reference of expected register contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] reg_rdata;
  logic [3:0] reg_addr;
  logic       reg_we, reg_re, tx_load, busy, err;
  logic [7:0] reg_wdata, tx_data;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  logic [7:0] mem     [16];
  logic [7:0] ref_mem [16];
  logic [7:0] wdat    [16];

  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  logic [7:0] tx_q      [$];
  int         tx_cyc_q  [$];

  spi_frame_controller #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_active (cs_active),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Register file with registered read data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  always @(negedge clk) begin
    if (reg_we) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (tx_load) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_start();
    cs_active = 1'b1;
    tick();
    chk("frame_start_err_clear", err, 0);
  endtask

  task automatic frame_end();
    cs_active = 1'b0;
    tick();
    tick();
    chk("frame_end_busy", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int rxc);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rxc      = cyc;
    rx_valid = 1'b0;
    repeat (7) tick();
  endtask

  task automatic do_write(input int a, input int n);
    int b0, b0t, dummy;
    int rc [16];
    b0  = wr_addr_q.size();
    b0t = tx_q.size();
    frame_start();
    send_byte(8'(a), dummy);
    for (int i = 0; i < n; i++) begin
      send_byte(wdat[i], rc[i]);
      ref_mem[(a + i) % 16] = wdat[i];
    end
    chk("wr_err", err, 0);
    frame_end();
    chk("wr_count", wr_addr_q.size() - b0, n);
    chk("wr_no_tx", tx_q.size() - b0t, 0);
    for (int i = 0; i < n; i++) begin
      if (b0 + i < wr_addr_q.size()) begin
        chk("wr_addr", wr_addr_q[b0 + i], (a + i) % 16);
        chk("wr_data", wr_data_q[b0 + i], wdat[i]);
        chk("wr_latency", wr_cyc_q[b0 + i] - rc[i], 0);
      end
    end
  endtask

  task automatic do_read(input int a, input int k);
    int b0, b0w;
    int rc [8];
    b0  = tx_q.size();
    b0w = wr_addr_q.size();
    frame_start();
    send_byte(8'h80 | 8'(a), rc[0]);
    for (int j = 1; j <= k; j++) send_byte(8'($urandom), rc[j]);
    chk("rd_err", err, 0);
    frame_end();
    chk("rd_count", tx_q.size() - b0, k + 1);
    chk("rd_no_write", wr_addr_q.size() - b0w, 0);
    for (int j = 0; j <= k; j++) begin
      if (b0 + j < tx_q.size()) begin
        chk("rd_data", tx_q[b0 + j], ref_mem[(a + j) % 16]);
        chk("rd_latency", tx_cyc_q[b0 + j] - rc[j], 2);
      end
    end
    chk("rd_addr_end", reg_addr, (a + k + 1) % 16);
  endtask

  task automatic do_rsvd(input logic [7:0] cmd);
    int b0w, b0t, rc;
    b0w = wr_addr_q.size();
    b0t = tx_q.size();
    frame_start();
    send_byte(cmd, rc);
    chk("rsvd_err_set", err, 1);
    chk("rsvd_busy", busy, 1);
    send_byte(8'($urandom), rc);
    send_byte(8'($urandom), rc);
    frame_end();
    chk("rsvd_err_sticky", err, 1);
    chk("rsvd_no_write", wr_addr_q.size() - b0w, 0);
    chk("rsvd_no_tx", tx_q.size() - b0t, 0);
  endtask

  initial begin
    int b0w, b0t, rc;
    logic [7:0] cmd;

    // Reset state
    tick();
    tick();
    chk("reset_outputs", {reg_addr, reg_we, reg_wdata, reg_re, tx_data, tx_load, busy, err}, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Fill every register through the DUT
    for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
    do_write(0, 16);

    // Directed write burst
    wdat[0] = 8'hAA;
    wdat[1] = 8'hBB;
    do_write(3, 2);
    chk("wr_burst_addr_after", reg_addr, 5);

    // Read burst across the address wrap
    wdat[0] = 8'h5A;
    wdat[1] = 8'hC3;
    do_write(15, 2);
    do_read(15, 1);

    // Reserved command bits, then next frame clears err
    do_rsvd(8'h13);
    do_read(6, 0);

    // Abort right after a read command
    b0t = tx_q.size();
    frame_start();
    rx_valid = 1'b1;
    rx_data  = 8'h84;
    tick();
    chk("abort_reg_re", reg_re, 1);
    rx_valid  = 1'b0;
    cs_active = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    repeat (5) tick();
    chk("abort_no_tx", tx_q.size() - b0t, 0);

    // Reset asserted together with a write byte
    b0w = wr_addr_q.size();
    frame_start();
    send_byte(8'h02, rc);
    rx_valid = 1'b1;
    rx_data  = 8'h66;
    rst      = 1'b1;
    tick();
    chk("rst_mid_write_outputs", {reg_addr, reg_we, reg_wdata, reg_re, tx_data, tx_load, busy, err}, 0);
    rst       = 1'b0;
    rx_valid  = 1'b0;
    cs_active = 1'b0;
    tick();
    tick();
    chk("rst_mid_write_no_we", wr_addr_q.size() - b0w, 0);

    // Chip-select fall coincides with a write byte
    b0w = wr_addr_q.size();
    frame_start();
    send_byte(8'h05, rc);
    cs_active = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 8'h77;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("cs_fall_busy", busy, 0);
    chk("cs_fall_no_we", wr_addr_q.size() - b0w, 0);

    // Back-to-back bytes during read prefetch
    b0t = tx_q.size();
    frame_start();
    rx_valid = 1'b1;
    rx_data  = 8'h81;
    tick();
    rx_data = 8'h00;
    tick();
    rx_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_err", err, 1);
    chk("b2b_tx_count", tx_q.size() - b0t, 1);
    if (b0t < tx_q.size()) chk("b2b_tx_data", tx_q[b0t], ref_mem[1]);
    frame_end();

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      int op, a, n;
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 15);
      if (op == 0) begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
        do_write(a, n);
      end else if (op == 1) begin
        do_read(a, $urandom_range(0, 4));
      end else begin
        cmd = {1'($urandom), 3'($urandom_range(1, 7)), 4'(a)};
        do_rsvd(cmd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
